// File: rtl/operand_fifo_pkg.sv
// Shared width helpers and pointer arithmetic for the operand FIFO.
// Pointers wrap explicitly, so DEPTH does not need to be a power of two.
package operand_fifo_pkg;

    // Width of a counter holding 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int unsigned ptr_wrap_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/operand_fifo_if.sv
// Producer/consumer port bundle of the operand FIFO.
// master is the pipeline side, slave is the FIFO itself.
interface operand_fifo_if
    import operand_fifo_pkg::*;
#(
    parameter int WL    = 8,
    parameter int DEPTH = 8
);
    localparam int CW = cnt_width(DEPTH);

    logic [WL-1:0] in;
    logic          wr_en;
    logic          rd_en;
    logic [WL-1:0] out;
    logic          empty;
    logic          full;
    logic          almost_full;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;

    modport master (
        output in, wr_en, rd_en,
        input  out, empty, full, almost_full, count, overflow, underflow
    );

    modport slave (
        input  in, wr_en, rd_en,
        output out, empty, full, almost_full, count, overflow, underflow
    );

endinterface

// File: rtl/operand_fifo_ptr.sv
// Wrapping storage pointer: counts 0..DEPTH-1 and returns to 0.
module fifo_ptr
    import operand_fifo_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PW    = ptr_width(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    logic [PW-1:0] ptr_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_reg <= '0;
        end else if (inc) begin
            ptr_reg <= PW'(ptr_wrap_inc(32'(ptr_reg), 32'(DEPTH)));
        end
    end

    assign ptr = ptr_reg;

endmodule

// File: rtl/operand_fifo.sv
// First-word-fall-through operand FIFO between ALU pipeline stages.
// Head word is presented combinationally; status flags decode the registered count.
module operand_fifo
    import operand_fifo_pkg::*;
#(
    parameter int WL       = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6
) (
    input  logic          CLK,
    input  logic          RST,
    operand_fifo_if.slave bus
);

    localparam int CW = cnt_width(DEPTH);
    localparam int PW = ptr_width(DEPTH);

    logic [WL-1:0] mem_reg [DEPTH];
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          overflow_reg;
    logic          underflow_reg;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          empty;
    logic          full;
    logic          do_wr;
    logic          do_rd;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CW'(DEPTH));

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_wr = bus.wr_en & (~full | bus.rd_en);
    assign do_rd = bus.rd_en & ~empty;

    fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
        .CLK (CLK),
        .RST (RST),
        .inc (do_wr),
        .ptr (wr_ptr)
    );

    fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
        .CLK (CLK),
        .RST (RST),
        .inc (do_rd),
        .ptr (rd_ptr)
    );

    always_ff @(posedge CLK) begin
        if (!RST && do_wr) begin
            mem_reg[wr_ptr] <= bus.in;
        end
    end

    always_comb begin
        count_next = count_reg;
        if (do_wr && !do_rd) begin
            count_next = count_reg + CW'(1);
        end else if (do_rd && !do_wr) begin
            count_next = count_reg - CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            count_reg     <= count_next;
            overflow_reg  <= bus.wr_en & full & ~bus.rd_en;
            underflow_reg <= bus.rd_en & empty;
        end
    end

    assign bus.empty       = empty;
    assign bus.full        = full;
    assign bus.almost_full = (count_reg >= CW'(AF_LEVEL));
    assign bus.count       = count_reg;
    assign bus.overflow    = overflow_reg;
    assign bus.underflow   = underflow_reg;
    assign bus.out         = empty ? '0 : mem_reg[rd_ptr];

endmodule

// File: tb/tb_operand_fifo.sv
// Self-checking bench: directed scenarios plus a randomized run against a queue model.
module tb_operand_fifo;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic rst_a;
    logic rst_b;

    operand_fifo_if #(.WL(8), .DEPTH(8)) ifa ();
    operand_fifo_if #(.WL(8), .DEPTH(5)) ifb ();

    operand_fifo #(.WL(8), .DEPTH(8), .AF_LEVEL(6)) dut_a (
        .CLK (CLK),
        .RST (rst_a),
        .bus (ifa)
    );

    operand_fifo #(.WL(8), .DEPTH(5), .AF_LEVEL(4)) dut_b (
        .CLK (CLK),
        .RST (rst_b),
        .bus (ifb)
    );

    int errors = 0;
    int checks = 0;

    // Reference model for dut_a: queue contents and the pulses expected after the last edge.
    logic [7:0] qa [$];
    logic       exp_ov;
    logic       exp_un;

    task automatic drive_a(input logic r, input logic w, input logic rd, input logic [7:0] d);
        int   n;
        logic push;
        logic pop;
        @(negedge CLK);
        rst_a     = r;
        ifa.wr_en = w;
        ifa.rd_en = rd;
        ifa.in    = d;
        @(posedge CLK);
        if (r) begin
            qa.delete();
            exp_ov = 1'b0;
            exp_un = 1'b0;
        end else begin
            n      = qa.size();
            push   = w && ((n < 8) || rd);
            pop    = rd && (n > 0);
            exp_ov = w && (n == 8) && !rd;
            exp_un = rd && (n == 0);
            if (pop) void'(qa.pop_front());
            if (push) qa.push_back(d);
        end
        #1;
        $display("txn A rst=%0b wr=%0b rd=%0b in=%h -> count=%0d out=%h ov=%0b un=%0b",
                 r, w, rd, d, ifa.count, ifa.out, ifa.overflow, ifa.underflow);
    endtask

    task automatic drive_b(input logic r, input logic w, input logic rd, input logic [7:0] d);
        @(negedge CLK);
        rst_b     = r;
        ifb.wr_en = w;
        ifb.rd_en = rd;
        ifb.in    = d;
        @(posedge CLK);
        #1;
        $display("txn B rst=%0b wr=%0b rd=%0b in=%h -> count=%0d out=%h ov=%0b un=%0b",
                 r, w, rd, d, ifb.count, ifb.out, ifb.overflow, ifb.underflow);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive_a(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
            checks += 6;
            if (ifa.count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", ifa.count); end
            if (ifa.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b expected 1", ifa.empty); end
            if (ifa.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b expected 0", ifa.full); end
            if (ifa.out !== 8'h00) begin errors++; $display("FAIL reset_out: got %h expected 00", ifa.out); end
            if (ifa.overflow !== 1'b0) begin errors++; $display("FAIL reset_ov: got %0b expected 0", ifa.overflow); end
            if (ifa.underflow !== 1'b0) begin errors++; $display("FAIL reset_un: got %0b expected 0", ifa.underflow); end
        end
        drive_a(1'b0, 1'b0, 1'b0, 8'h00);
        checks += 3;
        if (ifa.almost_full !== 1'b0) begin errors++; $display("FAIL reset_af: got %0b expected 0", ifa.almost_full); end
        if (ifa.overflow !== 1'b0) begin errors++; $display("FAIL post_reset_ov: got %0b expected 0", ifa.overflow); end
        if (ifa.underflow !== 1'b0) begin errors++; $display("FAIL post_reset_un: got %0b expected 0", ifa.underflow); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            drive_a(1'b0, 1'b1, 1'b0, 8'(8'h11 + i));
            checks += 4;
            if (ifa.count !== 4'(i + 1)) begin errors++; $display("FAIL fill_count: got %0d expected %0d", ifa.count, i + 1); end
            if (ifa.almost_full !== (i + 1 >= 6)) begin errors++; $display("FAIL fill_af: got %0b expected %0b at count %0d", ifa.almost_full, (i + 1 >= 6), i + 1); end
            if (ifa.full !== (i == 7)) begin errors++; $display("FAIL fill_full: got %0b expected %0b", ifa.full, (i == 7)); end
            if (ifa.out !== 8'h11) begin errors++; $display("FAIL fill_head: got %h expected 11", ifa.out); end
        end
    endtask

    task automatic test_overflow();
        drive_a(1'b0, 1'b1, 1'b0, 8'hAA);
        checks += 3;
        if (ifa.overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %0b expected 1", ifa.overflow); end
        if (ifa.count !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d expected 8", ifa.count); end
        if (ifa.out !== 8'h11) begin errors++; $display("FAIL ovf_head: got %h expected 11", ifa.out); end
        drive_a(1'b0, 1'b0, 1'b0, 8'h00);
        checks += 2;
        if (ifa.overflow !== 1'b0) begin errors++; $display("FAIL ovf_one_cycle: got %0b expected 0", ifa.overflow); end
        if (ifa.count !== 4'd8) begin errors++; $display("FAIL ovf_count_hold: got %0d expected 8", ifa.count); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 8; i++) begin
            checks += 1;
            if (ifa.out !== 8'(8'h11 + i)) begin errors++; $display("FAIL drain_order: got %h expected %h", ifa.out, 8'(8'h11 + i)); end
            drive_a(1'b0, 1'b0, 1'b1, 8'h00);
        end
        checks += 4;
        if (ifa.empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %0b expected 1", ifa.empty); end
        if (ifa.count !== 4'd0) begin errors++; $display("FAIL drain_count: got %0d expected 0", ifa.count); end
        if (ifa.out !== 8'h00) begin errors++; $display("FAIL drain_out: got %h expected 00", ifa.out); end
        if (ifa.underflow !== 1'b0) begin errors++; $display("FAIL drain_un: got %0b expected 0", ifa.underflow); end
    endtask

    task automatic test_empty_simul();
        drive_a(1'b0, 1'b0, 1'b1, 8'h00);
        checks += 2;
        if (ifa.underflow !== 1'b1) begin errors++; $display("FAIL unf_pulse: got %0b expected 1", ifa.underflow); end
        if (ifa.count !== 4'd0) begin errors++; $display("FAIL unf_count: got %0d expected 0", ifa.count); end
        drive_a(1'b0, 1'b1, 1'b1, 8'h5C);
        checks += 4;
        if (ifa.underflow !== 1'b1) begin errors++; $display("FAIL simul_un: got %0b expected 1", ifa.underflow); end
        if (ifa.count !== 4'd1) begin errors++; $display("FAIL simul_count: got %0d expected 1", ifa.count); end
        if (ifa.out !== 8'h5C) begin errors++; $display("FAIL simul_out: got %h expected 5c", ifa.out); end
        if (ifa.empty !== 1'b0) begin errors++; $display("FAIL simul_empty: got %0b expected 0", ifa.empty); end
        drive_a(1'b0, 1'b0, 1'b1, 8'h00);
        checks += 2;
        if (ifa.underflow !== 1'b0) begin errors++; $display("FAIL simul_un_clear: got %0b expected 0", ifa.underflow); end
        if (ifa.empty !== 1'b1) begin errors++; $display("FAIL simul_drain: got %0b expected 1", ifa.empty); end
    endtask

    task automatic test_full_simul();
        for (int i = 0; i < 8; i++) drive_a(1'b0, 1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 6; i++) begin
            checks += 1;
            if (ifa.out !== qa[0]) begin errors++; $display("FAIL full_simul_head: got %h expected %h", ifa.out, qa[0]); end
            drive_a(1'b0, 1'b1, 1'b1, 8'($urandom));
            checks += 2;
            if (ifa.count !== 4'd8) begin errors++; $display("FAIL full_simul_count: got %0d expected 8", ifa.count); end
            if (ifa.overflow !== 1'b0) begin errors++; $display("FAIL full_simul_ov: got %0b expected 0", ifa.overflow); end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] wr_seq;
        logic [7:0] rd_seq;
        drive_b(1'b1, 1'b0, 1'b0, 8'h00);
        wr_seq = 8'h40;
        rd_seq = 8'h40;
        for (int k = 0; k < 3; k++) begin
            drive_b(1'b0, 1'b1, 1'b0, wr_seq);
            wr_seq++;
        end
        checks += 1;
        if (ifb.count !== 3'd3) begin errors++; $display("FAIL wrap_prefill: got %0d expected 3", ifb.count); end
        for (int c = 0; c < 20; c++) begin
            checks += 1;
            if (ifb.out !== rd_seq) begin errors++; $display("FAIL wrap_order: got %h expected %h", ifb.out, rd_seq); end
            drive_b(1'b0, 1'b1, 1'b1, wr_seq);
            wr_seq++;
            rd_seq++;
            checks += 4;
            if (ifb.count !== 3'd3) begin errors++; $display("FAIL wrap_count: got %0d expected 3", ifb.count); end
            if (ifb.overflow !== 1'b0) begin errors++; $display("FAIL wrap_ov: got %0b expected 0", ifb.overflow); end
            if (ifb.underflow !== 1'b0) begin errors++; $display("FAIL wrap_un: got %0b expected 0", ifb.underflow); end
            if ((ifb.full !== 1'b0) || (ifb.empty !== 1'b0)) begin errors++; $display("FAIL wrap_flags: got full=%0b empty=%0b expected 0 0", ifb.full, ifb.empty); end
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 4; i++) drive_a(1'b0, 1'b1, 1'b0, 8'($urandom));
        checks += 1;
        if (ifa.count !== 4'd4) begin errors++; $display("FAIL midrst_pre: got %0d expected 4", ifa.count); end
        drive_a(1'b1, 1'b1, 1'b0, 8'hEE);
        checks += 3;
        if (ifa.count !== 4'd0) begin errors++; $display("FAIL midrst_count: got %0d expected 0", ifa.count); end
        if (ifa.empty !== 1'b1) begin errors++; $display("FAIL midrst_empty: got %0b expected 1", ifa.empty); end
        if (ifa.overflow !== 1'b0) begin errors++; $display("FAIL midrst_ov: got %0b expected 0", ifa.overflow); end
        drive_a(1'b1, 1'b0, 1'b1, 8'h00);
        drive_a(1'b0, 1'b0, 1'b0, 8'h00);
        checks += 2;
        if (ifa.underflow !== 1'b0) begin errors++; $display("FAIL midrst_un: got %0b expected 0", ifa.underflow); end
        if (ifa.empty !== 1'b1) begin errors++; $display("FAIL midrst_empty2: got %0b expected 1", ifa.empty); end
        drive_a(1'b0, 1'b1, 1'b0, 8'h33);
        checks += 2;
        if (ifa.out !== 8'h33) begin errors++; $display("FAIL midrst_first: got %h expected 33", ifa.out); end
        if (ifa.count !== 4'd1) begin errors++; $display("FAIL midrst_count1: got %0d expected 1", ifa.count); end
        drive_a(1'b0, 1'b0, 1'b1, 8'h00);
    endtask

    task automatic test_random();
        int   wr_pct;
        logic w;
        logic r;
        for (int c = 0; c < 400; c++) begin
            // Alternate write-heavy and read-heavy phases so both full and empty are visited.
            wr_pct = ((c / 40) % 2 == 0) ? 75 : 25;
            w = ($urandom_range(0, 99) < wr_pct);
            r = ($urandom_range(0, 99) < (100 - wr_pct));
            drive_a(1'b0, w, r, 8'($urandom));
            checks += 7;
            if (ifa.count !== 4'(qa.size())) begin errors++; $display("FAIL rand_count: got %0d expected %0d", ifa.count, qa.size()); end
            if (ifa.empty !== (qa.size() == 0)) begin errors++; $display("FAIL rand_empty: got %0b expected %0b", ifa.empty, (qa.size() == 0)); end
            if (ifa.full !== (qa.size() == 8)) begin errors++; $display("FAIL rand_full: got %0b expected %0b", ifa.full, (qa.size() == 8)); end
            if (ifa.almost_full !== (qa.size() >= 6)) begin errors++; $display("FAIL rand_af: got %0b expected %0b", ifa.almost_full, (qa.size() >= 6)); end
            if (ifa.out !== ((qa.size() == 0) ? 8'h00 : qa[0])) begin errors++; $display("FAIL rand_out: got %h expected %h", ifa.out, ((qa.size() == 0) ? 8'h00 : qa[0])); end
            if (ifa.overflow !== exp_ov) begin errors++; $display("FAIL rand_ov: got %0b expected %0b", ifa.overflow, exp_ov); end
            if (ifa.underflow !== exp_un) begin errors++; $display("FAIL rand_un: got %0b expected %0b", ifa.underflow, exp_un); end
        end
    endtask

    initial begin
        rst_a     = 1'b1;
        ifa.wr_en = 1'b0;
        ifa.rd_en = 1'b0;
        ifa.in    = 8'h00;
        rst_b     = 1'b1;
        ifb.wr_en = 1'b0;
        ifb.rd_en = 1'b0;
        ifb.in    = 8'h00;
        exp_ov    = 1'b0;
        exp_un    = 1'b0;

        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_empty_simul();
        test_full_simul();
        drive_a(1'b1, 1'b0, 1'b0, 8'h00);
        test_wrap();
        test_mid_reset();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/operand_fifo.md
Name: operand_fifo

Overview:
- Synchronous first-word-fall-through FIFO that sits between ALU pipeline stages.
- The producer pushes operands with wr_en; the consumer pulls them with rd_en.
- Counterpart to the fixed-latency delay line: the consumer end sets the latency, and the FIFO absorbs backpressure with full/empty/count status.

Parameters:
- WL, 8, data word width in bits.
- DEPTH, 8, number of storage entries; legal range DEPTH >= 2; need not be a power of two.
- AF_LEVEL, 6, almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH.

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- RST  input  1  synchronous active-high reset.
- in  input  WL  write data.
- wr_en  input  1  push request.
- rd_en  input  1  pop request.
- out  output  WL  head-of-queue data (FWFT).
- empty  output  1  no entries stored.
- full  output  1  DEPTH entries stored.
- almost_full  output  1  count >= AF_LEVEL.
- count  output  $clog2(DEPTH+1)  number of stored entries.
- overflow  output  1  one-cycle pulse: push rejected.
- underflow  output  1  one-cycle pulse: pop rejected.

Behaviour:
- Reset: one clock, synchronous and active-high. RST sampled high at posedge CLK clears wr_ptr, rd_ptr, count, overflow and underflow to 0.
- After reset: empty=1, full=0, almost_full=0, out=0. Storage array is not reset.
- Pointers: wr_ptr and rd_ptr each range 0..DEPTH-1 and wrap explicitly to 0 after DEPTH-1. No power-of-two masking.
- Effective push (do_wr): wr_en & (!full | rd_en).
- Effective pop (do_rd): rd_en & !empty.
- do_wr: mem[wr_ptr] <= in; wr_ptr advances.
- do_rd: rd_ptr advances.
- count: +1 on do_wr only, -1 on do_rd only, unchanged on both or neither.
- Full and simultaneous wr_en & rd_en: both succeed; count stays DEPTH; no overflow.
- Empty and simultaneous wr_en & rd_en: write succeeds; read is rejected with an underflow pulse; count becomes 1. There is no bypass of data from in to out.
- overflow: registered pulse, high for exactly the cycle after wr_en & full & !rd_en.
- underflow: registered pulse, high for exactly the cycle after rd_en & empty.
- A rejected access does not change pointers, count or memory.
- empty, full and almost_full are combinational decodes of registered count: empty = (count==0), full = (count==DEPTH).
- out = empty ? 0 : mem[rd_ptr], combinational from storage.
- Latency: a word written at edge N is visible on out after edge N with empty=0, so it can be popped at edge N+1 (one-cycle write-to-read latency).
- Reset mid-operation: all stored contents are discarded. Any wr_en/rd_en in the reset cycle is ignored and produces no overflow/underflow pulse.
- Throughput: one push and one pop per cycle sustained, indefinitely, in any state except empty-with-pop.

Decomposition:
- Shared package: clog2-based width helper for count/pointer widths; pointer-increment-with-wrap function.
- One natural sub-module: fifo_ptr (parameter DEPTH; inputs CLK, RST, inc; output ptr with explicit wrap). Instantiated twice, for wr_ptr and rd_ptr.
- Storage array and count logic stay in the top level.

Test Plan:
1. Reset check: assert RST for 2 cycles during random wr_en/rd_en -> count=0, empty=1, full=0, out=0, no overflow/underflow pulses.
2. Fill and drain, DEPTH=8: push 0x11..0x18 on consecutive cycles -> full=1, count=8, almost_full high from count=6. Then pop 8 times -> out reads 0x11..0x18 in order, empty=1 at end.
3. Overflow: when full, push 0xAA with rd_en=0 -> overflow pulses one cycle; count stays 8; contents unchanged (next pops still 0x11 first).
4. Underflow and empty simultaneous access: when empty, assert wr_en (in=0x5C) and rd_en together -> underflow pulses, count=1, out=0x5C next cycle.
5. Wrap-around with DEPTH=5: 20 cycles of simultaneous push/pop at count=3 with incrementing data -> count stays 3, output sequence strictly in order across pointer wrap, no flags.
6. Mid-operation reset: at count=4, assert RST one cycle with wr_en=1 -> count=0, empty=1, no overflow; the next push of 0x33 is the first word out.
